fp_decode: RTL and testbench
============================

# fp_decode

Sequential decoder for the team's 8-bit floating-point format (sign S, 3-bit exponent E, 4-bit significand F). It converts a format word back to a 12-bit two's-complement integer D = (-1)^S · F · 2^E. It sits on the consumer side of the 12-bit → float converter, for example in readback and self-check paths. Words enter and leave through valid/ready handshakes, and the exponent is applied by an iterative shifter.

## Interface
Parameters:
- none. Widths are fixed by the format and live in the shared package.

Ports:
- clk  in  1  Single clock. All state updates on the rising edge.
- rst  in  1  Reset. Synchronous, active-high.
- in_valid  in  1  A format word is present on S/E/F.
- in_ready  out  1  Block can accept a word. Combinational: high only in IDLE.
- S  in  1  Sign. 1 means negative.
- E  in  3  Exponent, 0..7.
- F  in  4  Significand, 0..15. No hidden bit.
- out_valid  out  1  D holds a finished result.
- out_ready  in  1  Downstream accepts D.
- D  out  12  Two's-complement result, registered.

## Operation
- FSM states: IDLE, SHIFT, DONE. Encoding is free.
- IDLE: in_ready=1. On in_valid&&in_ready, latch neg=S, mag={7'b0,F} (11 bits), cnt=E, then go to SHIFT.
- SHIFT, cnt≠0: mag←mag<<1, cnt←cnt−1, stay in SHIFT.
- SHIFT, cnt=0: D←neg ? −{1'b0,mag} : {1'b0,mag}, out_valid←1, go to DONE.
- DONE: D and out_valid hold until out_ready. On out_valid&&out_ready: out_valid←0, go to IDLE.
- Arithmetic and width rules:
  - Largest magnitude is 15·2^7 = 1920, so 11 bits never overflow.
  - Negation is 12-bit (~x+1). Result range is −1920..+1920.
  - No saturation or special codes. S=1,E=7,F=15 decodes to −1920.
- Zero handling: F=0 gives D=0 for any E and either S. Negative zero becomes 0x000. The shift sequence still runs to keep latency uniform.
- Reset values: state=IDLE, D=12'h000, out_valid=0, neg=0, mag=0, cnt=0. So in_ready=1 in the first cycle after reset.
- Reset mid-operation: the in-flight word is discarded and no output is produced. The block is back in IDLE on the next cycle.
- Inputs S/E/F are sampled only on the accept edge. Changes at any other time are ignored.

## Timing
- Serial build, accept at edge t0: out_valid is high after edge t0+E+1. Latency ranges 1..8 cycles.
- Output is held for as long as out_ready stays low.
- After output handshake at edge t1: in_ready=1 during cycle t1+1, so the next accept is possible at edge t1+1.
- Minimum initiation interval is E+3 cycles (serial) or 3 (barrel). Input is never accepted while a result is pending.
- out_valid and D come directly from registers. There is no combinational path from inputs to outputs other than the in_ready state decode.

## Configuration
- FPDEC_BARREL_EN
  - Defined: the accept edge loads mag={7'b0,F}<<E and cnt=0 in one step (barrel shift). Latency is exactly 1 cycle for every E.
  - Undefined: the serial one-bit-per-cycle shifter described above, with latency E+1.
- D values are identical in both builds. Only cycle timing differs.

## Structure
- Package fp_pkg holds:
  - constants FP_EXP_W=3, FP_SIG_W=4, TC_W=12, MAG_W=11;
  - typedef fpdec_state_t {IDLE, SHIFT, DONE}.
  - The converter in the opposite direction should reuse these constants.
- One natural sub-module: fpdec_shifter. It owns mag/cnt, load, step and done. It contains the FPDEC_BARREL_EN variant, so the top keeps the FSM, the sign apply and the handshakes.

## Test plan
- Reset, then S=0,E=3,F=5 with out_ready=1 → D=12'h028 (+40), out_valid after 4 cycles (serial) or 1 (barrel).
- S=1,E=7,F=15 → D=12'h880 (−1920). Serial latency is 8 cycles.
- S=1,E=5,F=0 → D=12'h000. Then S=0,E=0,F=9 → D=12'h009 with latency 1.
- Hold out_ready=0 for 10 cycles after a result → D and out_valid stable, in_ready=0, a new in_valid is not accepted. Release → exactly one transfer, then in_ready=1.
- Assert rst during SHIFT of a word with E=6 → no out_valid, D=0. Next word S=1,E=1,F=3 → D=12'hFFA (−6).
- Random sweep of all 256 S/E/F codes against the reference formula (−1)^S·F·2^E → all match, and latency matches the selected build.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the 8-bit float format (S, 3-bit E, 4-bit F) and
// the 12-bit two's-complement integer it maps to. The float encoder reuses
// the same constants.
package fp_pkg;

    localparam int FP_EXP_W = 3;
    localparam int FP_SIG_W = 4;
    localparam int TC_W     = 12;
    localparam int MAG_W    = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fpdec_state_t;

    // Sign-apply an 11-bit magnitude into a 12-bit two's-complement value.
    // A zero magnitude stays zero for either sign, so negative zero
    // decodes to 0x000.
    function automatic logic signed [TC_W-1:0] apply_sign(
        input logic             neg,
        input logic [MAG_W-1:0] mag
    );
        logic signed [TC_W-1:0] x;
        x = signed'({1'b0, mag});
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/fpdec_shifter.sv
// Exponent shifter for fp_decode: owns the magnitude and the remaining
// shift count. Default build shifts one bit per cycle. Defining
// FPDEC_BARREL_EN applies the whole exponent on the load edge instead.
module fpdec_shifter
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [FP_EXP_W-1:0] e,
    input  logic [FP_SIG_W-1:0] f,
    output logic [MAG_W-1:0]    mag,
    output logic                done
);

    localparam int PAD_W = MAG_W - FP_SIG_W;

    logic [MAG_W-1:0]    mag_q, mag_d;
    logic [FP_EXP_W-1:0] cnt_q, cnt_d;

    // Next magnitude/count: load a new significand or take one shift step.
    always_comb begin
        mag_d = mag_q;
        cnt_d = cnt_q;
        if (load) begin
`ifdef FPDEC_BARREL_EN
            mag_d = {{PAD_W{1'b0}}, f} << e;
            cnt_d = '0;
`else
            mag_d = {{PAD_W{1'b0}}, f};
            cnt_d = e;
`endif
        end else if (step && (cnt_q != '0)) begin
            mag_d = mag_q << 1;
            cnt_d = cnt_q - FP_EXP_W'(1);
        end
    end

    // Magnitude and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q <= '0;
            cnt_q <= '0;
        end else begin
            mag_q <= mag_d;
            cnt_q <= cnt_d;
        end
    end

    assign mag  = mag_q;
    assign done = (cnt_q == '0);

endmodule

// File: rtl/fp_decode.sv
// fp_decode: converts an 8-bit float word (S, E, F) to a 12-bit
// two's-complement integer D = (-1)^S * F * 2^E through valid/ready
// handshakes. Optional macro FPDEC_BARREL_EN (in fpdec_shifter) selects a
// single-cycle barrel shift instead of the serial shifter.
module fp_decode
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                S,
    input  logic [FP_EXP_W-1:0] E,
    input  logic [FP_SIG_W-1:0] F,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TC_W-1:0]     D
);

    fpdec_state_t           state_q, state_d;
    logic                   neg_q, neg_d;
    logic signed [TC_W-1:0] d_q, d_d;
    logic                   out_valid_q, out_valid_d;

    logic                   shf_load;
    logic                   shf_step;
    logic [MAG_W-1:0]       shf_mag;
    logic                   shf_done;

    fpdec_shifter u_shifter (
        .clk  (clk),
        .rst  (rst),
        .load (shf_load),
        .step (shf_step),
        .e    (E),
        .f    (F),
        .mag  (shf_mag),
        .done (shf_done)
    );

    // Handshake FSM: accept in IDLE, shift until the count drains, then
    // hold the signed result until downstream takes it.
    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        shf_load    = 1'b0;
        shf_step    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shf_load = 1'b1;
                    neg_d    = S;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (shf_done) begin
                    d_d         = apply_sign(neg_q, shf_mag);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    shf_step = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, sign, result and valid registers; reset discards any word
    // in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            neg_q       <= 1'b0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign D         = d_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fp_decode.sv
// Scoreboard bench for fp_decode: every accepted word pushes its expected
// D and latency; every output handshake pops and compares.
module tb_fp_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        S = 1'b0;
    logic [2:0]  E = 3'd0;
    logic [3:0]  F = 4'd0;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] D;

    typedef struct {
        logic [11:0] d;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_xfer   = 0;
    int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic ov_prev  = 1'b0;

    fp_decode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    function automatic logic [11:0] ref_d(input logic s, input logic [2:0] e, input logic [3:0] f);
        int v;
        v = int'(f) * (1 << e);
        if (s) v = -v;
        return v[11:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] e);
`ifdef FPDEC_BARREL_EN
        return 1;
`else
        return int'(e) + 1;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Single driver of out_ready.
    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard monitor: sees pre-edge values on each rising edge.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) chk("spurious_valid", 1, 0);
                else                chk("latency", cyc - sb[0].acc - 1, sb[0].lat);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("D", int'(D), int'(e.d));
                end
                n_xfer <= n_xfer + 1;
            end
            if (in_valid && in_ready) begin
                e.d   = ref_d(S, E, F);
                e.lat = ref_lat(E);
                e.acc = cyc;
                sb.push_back(e);
            end
        end
        ov_prev <= out_valid;
    end

    task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f);
        int k;
        @(negedge clk);
        S = s; E = e; F = f; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0 || !in_ready) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          perm[256];
        int          xfer0;
        logic [11:0] d_hold;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_D", int'(D), 0);

        // Directed words
        rdy_mode = 1;
        send(1'b0, 3'd3, 4'd5);   // +40
        wait_idle();
        send(1'b1, 3'd7, 4'd15);  // -1920
        wait_idle();
        send(1'b1, 3'd5, 4'd0);   // negative zero
        wait_idle();
        send(1'b0, 3'd0, 4'd9);   // +9, latency 1
        wait_idle();

        // Backpressure: result held, no new accept while pending
        rdy_mode = 0;
        send(1'b0, 3'd2, 4'd7);   // +28
        begin
            int k;
            k = 0;
            while (!out_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        chk("hold_valid_arrives", int'(out_valid), 1);
        d_hold = D;
        chk("hold_D_value", int'(d_hold), int'(ref_d(1'b0, 3'd2, 4'd7)));
        xfer0 = n_xfer;
        S = 1'b1; E = 3'd1; F = 4'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_D_stable", int'(D), int'(d_hold));
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        chk("release_one_xfer", n_xfer - xfer0, 1);
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);

        // Reset during the shift of an E=6 word
        send(1'b0, 3'd6, 4'd5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            chk("rst_mid_no_valid", int'(out_valid), 0);
            chk("rst_mid_D_zero", int'(D), 0);
            @(negedge clk);
        end
        send(1'b1, 3'd1, 4'd3);   // -6
        wait_idle();

        // Sweep all 256 codes in shuffled order with random backpressure
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        rdy_mode = 2;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            c = perm[i][7:0];
            send(c[7], c[6:4], c[3:0]);
        end
        rdy_mode = 1;
        wait_idle();
        chk("sweep_scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
